// File: rtl/regfile8_if.sv
// Register-file access bundle: write-back strobe and data, operand read ports A/B, debug read port and commit status.
// Every signal is point-to-point. The master drives the indices and write data; the slave returns data and status.
interface regfile8_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
);
  logic              rf_enable;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [CNT_W-1:0]  wr_count;
  logic [ADDR_W-1:0] last_wr;

  modport master (
    output rf_enable, wr_addr, wr_data, rd_addr_a, rd_addr_b, dbg_addr,
    input  rd_data_a, rd_data_b, dbg_data, wr_count, last_wr
  );

  modport slave (
    input  rf_enable, wr_addr, wr_data, rd_addr_a, rd_addr_b, dbg_addr,
    output rd_data_a, rd_data_b, dbg_data, wr_count, last_wr
  );
endinterface

// File: rtl/regfile8.sv
// NREG x DATA_W register file: one write port committing on the clock edge, two combinational read ports,
// a registered debug read port, and a commit counter. Define REGFILE_BYPASS_EN for same-cycle write-through on ports A/B.
module regfile8 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8,
  parameter int CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  regfile8_if.slave  rf
);

  localparam int NSLOT = 2 ** ADDR_W;

  // Storage spans the whole address space; slots at or above NREG are never written and are never read out.
  logic [DATA_W-1:0] r_regs [NSLOT];
  logic [CNT_W-1:0]  r_wr_count;
  logic [ADDR_W-1:0] r_last_wr;
  logic [DATA_W-1:0] r_dbg_data;

  logic              w_wr_ok;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic [DATA_W-1:0] w_dbg_next;

  assign w_wr_ok = rf.rf_enable && (int'(rf.wr_addr) < NREG);

  always_comb begin
    w_rd_a     = '0;
    w_rd_b     = '0;
    w_dbg_next = '0;
    if (int'(rf.rd_addr_a) < NREG) w_rd_a = r_regs[rf.rd_addr_a];
    if (int'(rf.rd_addr_b) < NREG) w_rd_b = r_regs[rf.rd_addr_b];
    if (int'(rf.dbg_addr) < NREG)  w_dbg_next = r_regs[rf.dbg_addr];
`ifdef REGFILE_BYPASS_EN
    // Only an accepted write forwards; the debug port always shows committed state.
    if (w_wr_ok && (rf.rd_addr_a == rf.wr_addr)) w_rd_a = rf.wr_data;
    if (w_wr_ok && (rf.rd_addr_b == rf.wr_addr)) w_rd_b = rf.wr_data;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOT; i++) r_regs[i] <= '0;
      r_wr_count <= '0;
      r_last_wr  <= '0;
      r_dbg_data <= '0;
    end else begin
      r_dbg_data <= w_dbg_next;
      if (w_wr_ok) begin
        r_regs[rf.wr_addr] <= rf.wr_data;
        r_wr_count         <= r_wr_count + CNT_W'(1);
        r_last_wr          <= rf.wr_addr;
      end
    end
  end

  assign rf.rd_data_a = w_rd_a;
  assign rf.rd_data_b = w_rd_b;
  assign rf.dbg_data  = r_dbg_data;
  assign rf.wr_count  = r_wr_count;
  assign rf.last_wr   = r_last_wr;

endmodule

// File: tb/tb_regfile8.sv
// Directed bench for regfile8: one default instance, plus a second instance with NREG=6 and CNT_W=4.
// The expected value for a same-cycle read of the written index follows REGFILE_BYPASS_EN.
module tb_regfile8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile8_if #(.DATA_W(16), .ADDR_W(3), .CNT_W(16)) if0 ();
  regfile8_if #(.DATA_W(16), .ADDR_W(3), .CNT_W(4))  if1 ();

  regfile8 #(.DATA_W(16), .ADDR_W(3), .NREG(8), .CNT_W(16)) u0 (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (if0.slave)
  );

  regfile8 #(.DATA_W(16), .ADDR_W(3), .NREG(6), .CNT_W(4)) u1 (
    .clk   (clk),
    .rst_n (rst_n),
    .rf    (if1.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if0.rf_enable = 1'b0; if0.wr_addr = '0; if0.wr_data = '0;
    if0.rd_addr_a = '0;   if0.rd_addr_b = '0; if0.dbg_addr = '0;
    if1.rf_enable = 1'b0; if1.wr_addr = '0; if1.wr_data = '0;
    if1.rd_addr_a = '0;   if1.rd_addr_b = '0; if1.dbg_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rd_a", if0.rd_data_a, 32'h0);
    chk("rst_cnt",  if0.wr_count,  32'h0);
    chk("rst_last", if0.last_wr,   32'h0);
    chk("rst_dbg",  if0.dbg_data,  32'h0);

    // Two writes on consecutive edges
    @(negedge clk);
    if0.rf_enable = 1'b1; if0.wr_addr = 3'd3; if0.wr_data = 16'hBEEF;
    @(negedge clk);
    if0.wr_addr = 3'd5; if0.wr_data = 16'h1234;
    @(negedge clk);
    if0.rf_enable = 1'b0; if0.rd_addr_a = 3'd3; if0.rd_addr_b = 3'd5;
    #1;
    chk("wr_rd_a_r3", if0.rd_data_a, 32'hBEEF);
    chk("wr_rd_b_r5", if0.rd_data_b, 32'h1234);
    chk("wr_cnt2",    if0.wr_count,  32'd2);
    chk("wr_last5",   if0.last_wr,   32'd5);

    // Same-cycle read of the register being written
    @(negedge clk);
    if0.rf_enable = 1'b1; if0.wr_addr = 3'd2; if0.wr_data = 16'hA5A5;
    if0.rd_addr_a = 3'd2; if0.rd_addr_b = 3'd2;
    #1;
    chk("rw_same_a", if0.rd_data_a, BYP ? 32'hA5A5 : 32'h0);
    chk("rw_same_b", if0.rd_data_b, BYP ? 32'hA5A5 : 32'h0);
    @(negedge clk);
    if0.rf_enable = 1'b0;
    #1;
    chk("rw_after_a", if0.rd_data_a, 32'hA5A5);
    chk("rw_after_b", if0.rd_data_b, 32'hA5A5);
    chk("rw_cnt3",    if0.wr_count,  32'd3);
    chk("rw_last2",   if0.last_wr,   32'd2);

    // Debug port samples pre-write contents
    @(negedge clk);
    if0.dbg_addr = 3'd3; if0.rf_enable = 1'b1; if0.wr_addr = 3'd3; if0.wr_data = 16'h00FF;
    @(posedge clk); #1;
    chk("dbg_old_r3", if0.dbg_data, 32'hBEEF);
    @(negedge clk);
    if0.rf_enable = 1'b0;
    @(posedge clk); #1;
    chk("dbg_new_r3", if0.dbg_data, 32'h00FF);

    // Idle cycles with garbage on the write bus change nothing
    @(negedge clk);
    if0.wr_addr = 3'd5; if0.wr_data = 16'hDEAD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if0.rd_addr_a = 3'd2; if0.rd_addr_b = 3'd5;
    #1;
    chk("idle_r2",   if0.rd_data_a, 32'hA5A5);
    chk("idle_r5",   if0.rd_data_b, 32'h1234);
    chk("idle_cnt",  if0.wr_count,  32'd4);
    chk("idle_last", if0.last_wr,   32'd3);

    // Register 0 is writable
    if0.rf_enable = 1'b1; if0.wr_addr = 3'd0; if0.wr_data = 16'h0001; if0.rd_addr_a = 3'd0;
    @(negedge clk);
    if0.rf_enable = 1'b0;
    #1;
    chk("r0_write", if0.rd_data_a, 32'h0001);
    chk("r0_cnt",   if0.wr_count,  32'd5);

    // NREG=6 instance: a valid write, then an out-of-range write that must be dropped
    if1.rf_enable = 1'b1; if1.wr_addr = 3'd1; if1.wr_data = 16'h1111;
    @(negedge clk);
    if1.wr_addr = 3'd7; if1.wr_data = 16'hFFFF; if1.rd_addr_a = 3'd7; if1.rd_addr_b = 3'd1;
    #1;
    chk("drop_nobyp", if1.rd_data_a, 32'h0);
    @(negedge clk);
    if1.rf_enable = 1'b0;
    #1;
    chk("drop_rd7",  if1.rd_data_a, 32'h0);
    chk("drop_r1",   if1.rd_data_b, 32'h1111);
    chk("drop_cnt",  if1.wr_count,  32'd1);
    chk("drop_last", if1.last_wr,   32'd1);
    if1.rf_enable = 1'b1; if1.wr_addr = 3'd6; if1.wr_data = 16'hFFFF;
    @(negedge clk);
    if1.rf_enable = 1'b0;
    #1;
    chk("drop6_cnt",  if1.wr_count, 32'd1);
    chk("drop6_last", if1.last_wr,  32'd1);

    // Asynchronous reset mid-cycle, with a write pending across the next edge
    if0.rd_addr_a = 3'd2; if0.rd_addr_b = 3'd5; if0.dbg_addr = 3'd2;
    @(posedge clk); #1;
    chk("pre_rst_dbg", if0.dbg_data, 32'hA5A5);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rd_a", if0.rd_data_a, 32'h0);
    chk("arst_rd_b", if0.rd_data_b, 32'h0);
    chk("arst_dbg",  if0.dbg_data,  32'h0);
    chk("arst_cnt",  if0.wr_count,  32'h0);
    chk("arst_last", if0.last_wr,   32'h0);
    chk("arst_u1_r1", if1.rd_data_b, 32'h0);
    if0.rf_enable = 1'b1; if0.wr_addr = 3'd4; if0.wr_data = 16'h7777;
    @(negedge clk);
    if0.rf_enable = 1'b0; if0.rd_addr_a = 3'd4;
    rst_n = 1'b1;
    #1;
    chk("rstwin_r4",  if0.rd_data_a, 32'h0);
    chk("rstwin_cnt", if0.wr_count,  32'h0);

    // CNT_W=4 counter wraps after 16 commits; addresses cycle 0..5
    for (int i = 0; i < 17; i++) begin
      if1.rf_enable = 1'b1; if1.wr_addr = 3'(i % 6); if1.wr_data = 16'(i);
      @(negedge clk);
      if (i == 15) begin
        #1;
        chk("wrap_cnt16", if1.wr_count, 32'd0);
      end
    end
    if1.rf_enable = 1'b0; if1.rd_addr_a = 3'd4;
    #1;
    chk("wrap_cnt17", if1.wr_count,  32'd1);
    chk("wrap_last",  if1.last_wr,   32'd4);
    chk("wrap_r4",    if1.rd_data_a, 32'h0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
